// File: rtl/wb_mailbox_if.sv
// rtl/wb_mailbox_if.sv - Wishbone classic slave bus bundle for the mailbox
interface wb_mailbox_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_mailbox.sv
// rtl/wb_mailbox.sv - Wishbone mailbox with host-to-core and core-to-host FIFOs
module wb_mailbox #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          DEPTH     = 4
) (
   input  logic        wb_clk_i,
   input  logic        rst_n,
   wb_mailbox_if.slave wbs,
   output logic [31:0] mb_data_o,
   output logic        mb_valid_o,
   input  logic        mb_rd_i,
   input  logic [31:0] rsp_data_i,
   input  logic        rsp_wr_i,
   output logic        rsp_full_o,
   output logic        irq_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic          r_ack;
   logic          r_we;
   logic [1:0]    r_reg;
   logic [3:0]    r_be;
   logic [31:0]   r_wdat;
   logic          r_ovf;
   logic          r_unf;
   logic          r_irq_en;
   logic          r_irq;

   logic [31:0]   r_h2c_mem [DEPTH];
   logic [AW-1:0] r_h2c_wp;
   logic [AW-1:0] r_h2c_rp;
   logic [CW-1:0] r_h2c_cnt;
   logic [31:0]   r_c2h_mem [DEPTH];
   logic [AW-1:0] r_c2h_wp;
   logic [AW-1:0] r_c2h_rp;
   logic [CW-1:0] r_c2h_cnt;

   logic          w_sel;
   logic          w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;
   logic          w_h2c_push_req, w_h2c_push, w_h2c_pop, w_ovf_set;
   logic          w_data_rd, w_c2h_push, w_c2h_pop, w_unf_set;
   logic          w_stat_wr, w_ctrl_wr, w_flush;
   logic [31:0]   w_status;
   logic [31:0]   w_rdata;
   logic          w_unused;

   assign w_unused = ^wbs.wbs_adr_i[1:0];

   assign w_sel = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack &
                  (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);

   assign w_h2c_full  = (r_h2c_cnt == CW'(DEPTH));
   assign w_h2c_empty = (r_h2c_cnt == '0);
   assign w_c2h_full  = (r_c2h_cnt == CW'(DEPTH));
   assign w_c2h_empty = (r_c2h_cnt == '0);

   // The ack cycle is the commit cycle: every side effect keys off r_ack.
   assign w_h2c_push_req = r_ack & r_we & (r_reg == 2'd0) & (r_be == 4'hF);
   assign w_data_rd      = r_ack & ~r_we & (r_reg == 2'd0);
   assign w_stat_wr      = r_ack & r_we & (r_reg == 2'd1) & r_be[0];
   assign w_ctrl_wr      = r_ack & r_we & (r_reg == 2'd2) & r_be[0];
   assign w_flush        = w_ctrl_wr & r_wdat[1];

   assign w_h2c_pop  = mb_rd_i & ~w_h2c_empty;
   assign w_h2c_push = w_h2c_push_req & (~w_h2c_full | w_h2c_pop);
   assign w_ovf_set  = w_h2c_push_req & w_h2c_full & ~w_h2c_pop;
   assign w_c2h_pop  = w_data_rd & ~w_c2h_empty;
   assign w_unf_set  = w_data_rd & w_c2h_empty;
   assign w_c2h_push = rsp_wr_i & (~w_c2h_full | w_c2h_pop);

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_ack  <= 1'b0;
         r_we   <= 1'b0;
         r_reg  <= 2'd0;
         r_be   <= 4'h0;
         r_wdat <= 32'h0;
      end else begin
         r_ack <= w_sel;
         if (w_sel) begin
            r_we   <= wbs.wbs_we_i;
            r_reg  <= wbs.wbs_adr_i[3:2];
            r_be   <= wbs.wbs_sel_i;
            r_wdat <= wbs.wbs_dat_i;
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_stat_wr && r_wdat[4]) r_ovf <= 1'b0;
         else if (w_ovf_set)         r_ovf <= 1'b1;
         if (w_stat_wr && r_wdat[5]) r_unf <= 1'b0;
         else if (w_unf_set)         r_unf <= 1'b1;
         if (w_ctrl_wr) r_irq_en <= r_wdat[0];
         r_irq <= r_irq_en & ~w_c2h_empty;
      end
   end

   // Flush wins over any concurrent core-side push or pop.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_h2c_wp  <= '0;
         r_h2c_rp  <= '0;
         r_h2c_cnt <= '0;
         r_c2h_wp  <= '0;
         r_c2h_rp  <= '0;
         r_c2h_cnt <= '0;
      end else if (w_flush) begin
         r_h2c_wp  <= '0;
         r_h2c_rp  <= '0;
         r_h2c_cnt <= '0;
         r_c2h_wp  <= '0;
         r_c2h_rp  <= '0;
         r_c2h_cnt <= '0;
      end else begin
         if (w_h2c_push) r_h2c_wp <= r_h2c_wp + 1'b1;
         if (w_h2c_pop)  r_h2c_rp <= r_h2c_rp + 1'b1;
         case ({w_h2c_push, w_h2c_pop})
            2'b10:   r_h2c_cnt <= r_h2c_cnt + 1'b1;
            2'b01:   r_h2c_cnt <= r_h2c_cnt - 1'b1;
            default: r_h2c_cnt <= r_h2c_cnt;
         endcase
         if (w_c2h_push) r_c2h_wp <= r_c2h_wp + 1'b1;
         if (w_c2h_pop)  r_c2h_rp <= r_c2h_rp + 1'b1;
         case ({w_c2h_push, w_c2h_pop})
            2'b10:   r_c2h_cnt <= r_c2h_cnt + 1'b1;
            2'b01:   r_c2h_cnt <= r_c2h_cnt - 1'b1;
            default: r_c2h_cnt <= r_c2h_cnt;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_h2c_push) r_h2c_mem[r_h2c_wp] <= r_wdat;
      if (w_c2h_push) r_c2h_mem[r_c2h_wp] <= rsp_data_i;
   end

   always_comb begin
      w_status        = 32'h0;
      w_status[0]     = w_h2c_full;
      w_status[1]     = w_h2c_empty;
      w_status[2]     = w_c2h_full;
      w_status[3]     = w_c2h_empty;
      w_status[4]     = r_ovf;
      w_status[5]     = r_unf;
      w_status[12:8]  = 5'(r_h2c_cnt);
      w_status[20:16] = 5'(r_c2h_cnt);
   end

   always_comb begin
      w_rdata = 32'h0;
      case (r_reg)
         2'd0:    w_rdata = w_c2h_empty ? 32'h0 : r_c2h_mem[r_c2h_rp];
         2'd1:    w_rdata = w_status;
         2'd2:    w_rdata = {31'h0, r_irq_en};
         default: w_rdata = 32'h0;
      endcase
   end

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = (r_ack && !r_we) ? w_rdata : 32'h0;

   assign mb_valid_o = ~w_h2c_empty;
   assign mb_data_o  = w_h2c_empty ? 32'h0 : r_h2c_mem[r_h2c_rp];
   assign rsp_full_o = w_c2h_full;
   assign irq_o      = r_irq;
endmodule

// File: tb/tb_wb_mailbox.sv
// tb/tb_wb_mailbox.sv - self-checking bench for wb_mailbox against a queue model
module tb_wb_mailbox;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mb_data;
   logic        mb_valid;
   logic        mb_rd;
   logic [31:0] rsp_data;
   logic        rsp_wr;
   logic        rsp_full;
   logic        irq;

   wb_mailbox_if bus ();

   wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .wb_clk_i  (clk),
      .rst_n     (rst_n),
      .wbs       (bus),
      .mb_data_o (mb_data),
      .mb_valid_o(mb_valid),
      .mb_rd_i   (mb_rd),
      .rsp_data_i(rsp_data),
      .rsp_wr_i  (rsp_wr),
      .rsp_full_o(rsp_full),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] q_h2c[$];
   logic [31:0] q_c2h[$];
   bit          m_ovf, m_unf, m_irq_en, m_irq;
   bit          rand_core = 1'b0;
   bit          pop_at_commit = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s        = 32'h0;
      s[0]     = (q_h2c.size() == DEPTH);
      s[1]     = (q_h2c.size() == 0);
      s[2]     = (q_c2h.size() == DEPTH);
      s[3]     = (q_c2h.size() == 0);
      s[4]     = m_ovf;
      s[5]     = m_unf;
      s[12:8]  = 5'(q_h2c.size());
      s[20:16] = 5'(q_c2h.size());
      return s;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] adr);
      case (adr[3:2])
         2'd0:    return (q_c2h.size() > 0) ? q_c2h[0] : 32'h0;
         2'd1:    return m_status();
         2'd2:    return {31'h0, m_irq_en};
         default: return 32'h0;
      endcase
   endfunction

   function automatic void m_reset();
      q_h2c.delete();
      q_c2h.delete();
      m_ovf = 0; m_unf = 0; m_irq_en = 0; m_irq = 0;
   endfunction

   // One clock edge: update the model from the inputs present at the edge, then check outputs.
   task automatic tick(input bit commit, input logic [31:0] adr, input bit we,
                       input logic [3:0] sel, input logic [31:0] dat);
      bit          pre_irq, flush;
      logic [31:0] tmp;
      if (rand_core) begin
         mb_rd    = ($urandom_range(0, 2) == 0);
         rsp_wr   = ($urandom_range(0, 2) == 0);
         rsp_data = $urandom;
      end
      pre_irq = m_irq_en && (q_c2h.size() > 0);
      flush   = 0;
      if (mb_rd && q_h2c.size() > 0) tmp = q_h2c.pop_front();
      if (commit) begin
         case (adr[3:2])
            2'd0: begin
               if (we) begin
                  if (sel == 4'hF) begin
                     if (q_h2c.size() < DEPTH) q_h2c.push_back(dat);
                     else m_ovf = 1;
                  end
               end else begin
                  if (q_c2h.size() > 0) tmp = q_c2h.pop_front();
                  else m_unf = 1;
               end
            end
            2'd1: if (we && sel[0]) begin
               if (dat[4]) m_ovf = 0;
               if (dat[5]) m_unf = 0;
            end
            2'd2: if (we && sel[0]) begin
               m_irq_en = dat[0];
               flush    = dat[1];
            end
            default: ;
         endcase
      end
      if (rsp_wr && q_c2h.size() < DEPTH) q_c2h.push_back(rsp_data);
      if (flush) begin
         q_h2c.delete();
         q_c2h.delete();
      end
      @(posedge clk);
      #1;
      m_irq = pre_irq;
      chk("mb_valid", {31'h0, mb_valid}, {31'h0, q_h2c.size() > 0});
      if (q_h2c.size() > 0) chk("mb_data", mb_data, q_h2c[0]);
      chk("rsp_full", {31'h0, rsp_full}, {31'h0, q_c2h.size() == DEPTH});
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
   endtask

   task automatic idle();
      tick(0, 32'h0, 0, 4'h0, 32'h0);
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                          input logic [31:0] dat, output logic [31:0] rdat);
      logic [31:0] exp;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
      bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
      tick(0, adr, we, sel, dat);
      chk("ack_rise", {31'h0, bus.wbs_ack_o}, 32'h1);
      rdat = bus.wbs_dat_o;
      if (!we) begin
         exp = m_read(adr);
         chk("rdata", rdat, exp);
      end
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      if (pop_at_commit) mb_rd = 1;
      tick(1, adr, we, sel, dat);
      if (pop_at_commit) mb_rd = 0;
      chk("ack_fall", {31'h0, bus.wbs_ack_o}, 32'h0);
   endtask

   task automatic wb_noack(input logic [31:0] adr, input bit cyc);
      bus.wbs_cyc_i = cyc; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = adr; bus.wbs_dat_i = $urandom;
      for (int i = 0; i < 8; i++) begin
         tick(0, adr, 1, 4'hF, 32'h0);
         chk("noack", {31'h0, bus.wbs_ack_o}, 32'h0);
      end
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
   endtask

   task automatic core_push(input logic [31:0] d);
      rsp_wr = 1; rsp_data = d;
      idle();
      rsp_wr = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      rst_n = 0; mb_rd = 0; rsp_wr = 0; rsp_data = 0;
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
      m_reset();
      #12;
      chk("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      chk("rst_dat", bus.wbs_dat_o, 32'h0);
      chk("rst_valid", {31'h0, mb_valid}, 32'h0);
      chk("rst_mbdata", mb_data, 32'h0);
      chk("rst_full", {31'h0, rsp_full}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rst_n = 1;
      idle();

      // Single push then core pop
      wb_xfer(BASE, 1, 4'hF, 32'hDEAD_BEEF, rd);
      chk("push_valid", {31'h0, mb_valid}, 32'h1);
      chk("push_data", mb_data, 32'hDEAD_BEEF);
      mb_rd = 1; idle(); mb_rd = 0;
      chk("pop_valid", {31'h0, mb_valid}, 32'h0);

      // Partial byte select: acked, no push
      wb_xfer(BASE, 1, 4'h3, 32'h1234_5678, rd);
      chk("partial_sel", {31'h0, mb_valid}, 32'h0);

      // Overflow on DEPTH+1 pushes, then W1C
      for (int i = 0; i <= DEPTH; i++) wb_xfer(BASE, 1, 4'hF, 32'hA000_0000 + i, rd);
      wb_xfer(BASE + 4, 0, 4'hF, 32'h0, rd);
      chk("status_ovf", rd, 32'h0000_0419);
      wb_xfer(BASE + 4, 1, 4'hF, 32'h10, rd);
      wb_xfer(BASE + 4, 0, 4'hF, 32'h0, rd);
      chk("status_w1c", rd, 32'h0000_0409);

      // Core responses, interrupt, underflow
      core_push(32'h11);
      core_push(32'h22);
      wb_xfer(BASE + 8, 1, 4'hF, 32'h1, rd);
      idle();
      chk("irq_on", {31'h0, irq}, 32'h1);
      wb_xfer(BASE, 0, 4'hF, 32'h0, rd);
      chk("rd_first", rd, 32'h11);
      wb_xfer(BASE, 0, 4'hF, 32'h0, rd);
      chk("rd_second", rd, 32'h22);
      chk("irq_lag", {31'h0, irq}, 32'h1);
      idle();
      chk("irq_off", {31'h0, irq}, 32'h0);
      wb_xfer(BASE, 0, 4'hF, 32'h0, rd);
      chk("rd_empty", rd, 32'h0);
      wb_xfer(BASE + 4, 0, 4'hF, 32'h0, rd);
      chk("unf_bit", {31'h0, rd[5]}, 32'h1);

      // Unselected requests
      wb_noack(BASE + 32'h10, 1);
      wb_noack(BASE, 0);

      // Flush, refill, push into full FIFO with concurrent core pop
      wb_xfer(BASE + 8, 1, 4'hF, 32'h2, rd);
      wb_xfer(BASE + 4, 1, 4'hF, 32'h30, rd);
      for (int i = 0; i < DEPTH; i++) wb_xfer(BASE, 1, 4'hF, 32'hB0 + i, rd);
      pop_at_commit = 1;
      wb_xfer(BASE, 1, 4'hF, 32'hCAFE, rd);
      pop_at_commit = 0;
      wb_xfer(BASE + 4, 0, 4'hF, 32'h0, rd);
      chk("conc_cnt", {27'h0, rd[12:8]}, DEPTH);
      chk("conc_ovf", {31'h0, rd[4]}, 32'h0);
      for (int i = 1; i <= DEPTH; i++) begin
         chk("conc_order", mb_data, (i == DEPTH) ? 32'hCAFE : 32'hB0 + i);
         mb_rd = 1; idle(); mb_rd = 0;
      end

      // Randomized traffic on both sides
      rand_core = 1;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 7))
            0, 1: wb_xfer(BASE, 1, ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF, $urandom, rd);
            2:    wb_xfer(BASE, 0, 4'hF, 32'h0, rd);
            3:    wb_xfer(BASE + 4, 0, 4'hF, 32'h0, rd);
            4:    wb_xfer(BASE + 4, 1, 4'($urandom), $urandom, rd);
            5:    wb_xfer(BASE + 8, 1, ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF,
                          {30'h0, ($urandom_range(0, 7) == 0), 1'($urandom)}, rd);
            6:    wb_xfer(BASE + 8 + 4 * $urandom_range(0, 1), $urandom_range(0, 1) == 1,
                          4'hF, $urandom, rd);
            default: idle();
         endcase
      end
      rand_core = 0; mb_rd = 0; rsp_wr = 0;

      // Reset during a pending DATA write
      wb_xfer(BASE + 8, 1, 4'hF, 32'h1, rd);
      for (int i = 0; i < DEPTH; i++) core_push(32'h100 + i);
      wb_xfer(BASE, 1, 4'hF, 32'h5555, rd);
      idle();
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'h7777;
      tick(0, BASE, 1, 4'hF, 32'h7777);
      #2 rst_n = 0;
      #1;
      chk("arst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      chk("arst_dat", bus.wbs_dat_o, 32'h0);
      chk("arst_valid", {31'h0, mb_valid}, 32'h0);
      chk("arst_mbdata", mb_data, 32'h0);
      chk("arst_full", {31'h0, rsp_full}, 32'h0);
      chk("arst_irq", {31'h0, irq}, 32'h0);
      m_reset();
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      #1 rst_n = 1;
      idle();
      chk("post_rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      wb_xfer(BASE + 4, 0, 4'hF, 32'h0, rd);
      chk("post_rst_status", rd, 32'h0000_000A);
      wb_xfer(BASE + 8, 0, 4'hF, 32'h0, rd);
      chk("post_rst_ctrl", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
